ps2_mouse_tracker: RTL and testbench

//  Receives the PS/2 mouse stream (device-to-host only; mouse already in stream mode),

---
 rtl/ps2_mouse_tracker.sv | 226 ++++++++++++++++++++++
 tb/tb_ps2_mouse_tracker.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_tracker.sv
// ps2_mouse_tracker: receives the device-to-host PS/2 mouse stream, assembles
// 3-byte movement packets and keeps an absolute, clamped cursor position plus
// the left-button state for the downstream image decoder.
module ps2_mouse_tracker #(
    parameter int X_MAX   = 319,
    parameter int Y_MAX   = 239,
    parameter int X_INIT  = 160,
    parameter int Y_INIT  = 120,
    parameter int TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [8:0] x,
    output logic [8:0] y,
    output logic       leftclick,
    output logic       packet_valid,
    output logic       frame_error
);

    localparam int               CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [8:0]       X_MAX_V   = 9'(X_MAX);
    localparam logic [8:0]       Y_MAX_V   = 9'(Y_MAX);
    localparam logic [8:0]       X_INIT_V  = 9'(X_INIT);
    localparam logic [8:0]       Y_INIT_V  = 9'(Y_INIT);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    // Odd parity holds when data bits plus parity bit carry an odd number of ones.
    function automatic logic odd_ones(input logic [8:0] v);
        return ^v;
    endfunction

    // Clamp a signed 11-bit coordinate into [0, max_v].
    function automatic logic [8:0] clamp_axis(input logic signed [10:0] v,
                                              input logic [8:0]         max_v);
        logic [8:0] r;
        if (v < 11'sd0) begin
            r = 9'd0;
        end else if (v > $signed({2'b00, max_v})) begin
            r = max_v;
        end else begin
            r = v[8:0];
        end
        return r;
    endfunction

    logic             clk_meta_r, clk_sync_r, clk_prev_r;
    logic             data_meta_r, data_sync_r;
    logic             fall_s, bit_s;
    logic [1:0]       state_r;
    logic [7:0]       shift_r;
    logic [2:0]       bit_cnt_r;
    logic             parity_r;
    logic [1:0]       idx_r;
    logic [7:0]       b0_r, b1_r;
    logic [CNT_W-1:0] cnt_r;
    logic             byte_ok_s, byte_bad_s, timeout_s;
    logic signed [10:0] x_sum_s, y_sum_s;
    logic [8:0]       x_next_s, y_next_s;

    // Two-flop synchronisers for the pad signals, plus a history flop for edge detect.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta_r  <= 1'b1;
            clk_sync_r  <= 1'b1;
            clk_prev_r  <= 1'b1;
            data_meta_r <= 1'b1;
            data_sync_r <= 1'b1;
        end else begin
            clk_meta_r  <= ps2_clk;
            clk_sync_r  <= clk_meta_r;
            clk_prev_r  <= clk_sync_r;
            data_meta_r <= ps2_data;
            data_sync_r <= data_meta_r;
        end
    end

    // Edge detect, byte accept/reject decision and timeout condition.
    always_comb begin
        fall_s     = clk_prev_r & ~clk_sync_r;
        bit_s      = data_sync_r;
        byte_ok_s  = 1'b0;
        byte_bad_s = 1'b0;
        if (fall_s && (state_r == ST_STOP)) begin
            if (bit_s && odd_ones({shift_r, parity_r})) begin
                byte_ok_s = 1'b1;
            end else begin
                byte_bad_s = 1'b1;
            end
        end else begin
            byte_ok_s  = 1'b0;
            byte_bad_s = 1'b0;
        end
        timeout_s = !fall_s && (cnt_r == CNT_LIMIT) &&
                    ((state_r != ST_IDLE) || (idx_r != 2'd0));
    end

    // New cursor position from the stored dx and the dy byte arriving now.
    always_comb begin
        x_sum_s = $signed({2'b00, x}) + $signed({{2{b0_r[4]}}, b0_r[4], b1_r});
        y_sum_s = $signed({2'b00, y}) - $signed({{2{b0_r[5]}}, b0_r[5], shift_r});
        if (b0_r[6]) begin
            x_next_s = x;
        end else begin
            x_next_s = clamp_axis(x_sum_s, X_MAX_V);
        end
        if (b0_r[7]) begin
            y_next_s = y;
        end else begin
            y_next_s = clamp_axis(y_sum_s, Y_MAX_V);
        end
    end

    // Byte receiver: one transition per PS/2 falling edge, forced idle on timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            shift_r   <= 8'd0;
            bit_cnt_r <= 3'd0;
            parity_r  <= 1'b0;
        end else if (timeout_s) begin
            state_r <= ST_IDLE;
        end else if (fall_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (!bit_s) begin
                        state_r   <= ST_DATA;
                        bit_cnt_r <= 3'd0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    shift_r   <= {bit_s, shift_r[7:1]};
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        state_r <= ST_PARITY;
                    end else begin
                        state_r <= ST_DATA;
                    end
                end
                ST_PARITY: begin
                    parity_r <= bit_s;
                    state_r  <= ST_STOP;
                end
                ST_STOP: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

    // Inactivity counter: clears on each falling edge and saturates at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (fall_s) begin
            cnt_r <= '0;
        end else if (cnt_r != CNT_LIMIT) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Packet assembly and registered cursor/button/pulse outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_r        <= 2'd0;
            b0_r         <= 8'd0;
            b1_r         <= 8'd0;
            x            <= X_INIT_V;
            y            <= Y_INIT_V;
            leftclick    <= 1'b0;
            packet_valid <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            packet_valid <= 1'b0;
            frame_error  <= byte_bad_s | timeout_s;
            if (byte_bad_s || timeout_s) begin
                idx_r <= 2'd0;
            end else if (byte_ok_s) begin
                case (idx_r)
                    2'd0: begin
                        // Header bytes always carry bit3 set; anything else is a resync.
                        if (shift_r[3]) begin
                            b0_r  <= shift_r;
                            idx_r <= 2'd1;
                        end else begin
                            idx_r <= 2'd0;
                        end
                    end
                    2'd1: begin
                        b1_r  <= shift_r;
                        idx_r <= 2'd2;
                    end
                    2'd2: begin
                        x            <= x_next_s;
                        y            <= y_next_s;
                        leftclick    <= b0_r[0];
                        packet_valid <= 1'b1;
                        idx_r        <= 2'd0;
                    end
                    default: begin
                        idx_r <= 2'd0;
                    end
                endcase
            end else begin
                idx_r <= idx_r;
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// tb_ps2_mouse_tracker: directed and randomized PS/2 packet stimulus checked
// against a packet-level reference model of the cursor tracker.
module tb_ps2_mouse_tracker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [8:0] x, y;
    logic       leftclick, packet_valid, frame_error;

    int vectors = 0;
    int miscompares = 0;
    int pv_cnt = 0;
    int fe_cnt = 0;

    // Reference model state
    int         mx, my, mleft, m_idx, exp_pv, exp_fe;
    logic [7:0] m_b0, m_b1;
    logic [7:0] rb0, rb1, rb2, junk;
    int         bad_sel;

    ps2_mouse_tracker #(
        .X_MAX(319), .Y_MAX(239), .X_INIT(160), .Y_INIT(120), .TIMEOUT(200)
    ) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .x(x), .y(y), .leftclick(leftclick),
        .packet_valid(packet_valid), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    // Count high cycles of each pulse output, sampled away from the active edge.
    always @(negedge clk) begin
        if (packet_valid === 1'b1) pv_cnt <= pv_cnt + 1;
        if (frame_error === 1'b1) fe_cnt <= fe_cnt + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "/x"}, 32'(x), 32'(mx));
        check({tag, "/y"}, 32'(y), 32'(my));
        check({tag, "/left"}, 32'(leftclick), 32'(mleft));
        check({tag, "/pv_count"}, 32'(pv_cnt), 32'(exp_pv));
        check({tag, "/fe_count"}, 32'(fe_cnt), 32'(exp_fe));
    endtask

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    // Packet-level model: what one received byte does to the tracker.
    task automatic model_byte(input logic [7:0] b, input bit ok);
        int dx, dy;
        if (!ok) begin
            exp_fe++;
            m_idx = 0;
        end else if (m_idx == 0) begin
            if (b[3]) begin
                m_b0 = b;
                m_idx = 1;
            end
        end else if (m_idx == 1) begin
            m_b1 = b;
            m_idx = 2;
        end else begin
            dx = m_b0[4] ? int'(m_b1) - 256 : int'(m_b1);
            dy = m_b0[5] ? int'(b) - 256 : int'(b);
            if (!m_b0[6]) mx = clampi(mx + dx, 319);
            if (!m_b0[7]) my = clampi(my - dy, 239);
            mleft = m_b0[0];
            exp_pv++;
            m_idx = 0;
        end
    endtask

    task automatic do_reset();
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        reset = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(1);
        mx = 160; my = 120; mleft = 0; m_idx = 0;
    endtask

    // Drive the first nbits of an 11-bit frame (bit0 = start); data changes mid-high.
    task automatic send_frame(input logic [10:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_clk = 1'b1;
            wait_clk(10);
            ps2_data = frame[i];
            wait_clk(10);
            ps2_clk = 1'b0;
            wait_clk(20);
        end
        ps2_clk = 1'b1;
        wait_clk(10);
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad, input string tag);
        logic par;
        par = (~^b) ^ bad;
        send_frame({1'b1, par, b, 1'b0}, 11);
        model_byte(b, !bad);
        wait_clk(5);
        check_all(tag);
    endtask

    task automatic send_packet(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input string tag);
        send_byte(a, 1'b0, {tag, ".b0"});
        send_byte(b, 1'b0, {tag, ".b1"});
        send_byte(c, 1'b0, {tag, ".b2"});
    endtask

    initial begin
        exp_pv = 0; exp_fe = 0;
        m_b0 = 8'd0; m_b1 = 8'd0;

        // 1. Reset state and quiet idle
        do_reset();
        check_all("reset");
        wait_clk(100);
        check_all("idle100");

        // 2. Simple positive move with left button
        send_packet(8'h09, 8'h05, 8'h03, "pkt_basic");
        check("pkt_basic/x_const", 32'(x), 32'd165);
        check("pkt_basic/y_const", 32'(y), 32'd117);

        // 3. Negative deltas from reset
        do_reset();
        send_packet(8'h38, 8'hF6, 8'hFB, "pkt_neg");
        check("pkt_neg/x_const", 32'(x), 32'd150);
        check("pkt_neg/y_const", 32'(y), 32'd125);

        // 4. Clamp at X_MAX, then X overflow leaves x alone
        do_reset();
        for (int i = 0; i < 5; i++) send_packet(8'h08, 8'h7F, 8'h00, "pkt_clamp");
        check("pkt_clamp/x_const", 32'(x), 32'd319);
        send_packet(8'h48, 8'h7F, 8'h00, "pkt_xovf");

        // 5. Bad parity on byte1, then a good packet
        do_reset();
        send_byte(8'h08, 1'b0, "badpar.b0");
        send_byte(8'h01, 1'b1, "badpar.b1");
        send_packet(8'h08, 8'h01, 8'h01, "after_badpar");
        check("after_badpar/x_const", 32'(x), 32'd161);

        // 6. Resync byte, timeout of a partial byte, reset mid-packet
        send_byte(8'h01, 1'b0, "resync");
        send_frame({1'b1, 1'b1, 8'h55, 1'b0}, 4);
        wait_clk(250);
        exp_fe++;
        m_idx = 0;
        check_all("timeout");
        send_packet(8'h08, 8'h03, 8'h00, "after_timeout");
        send_byte(8'h09, 1'b0, "midpkt.b0");
        send_byte(8'h10, 1'b0, "midpkt.b1");
        do_reset();
        check_all("midpkt_reset");
        send_packet(8'h08, 8'h02, 8'h00, "after_reset");
        check("after_reset/x_const", 32'(x), 32'd162);

        // Randomized packets with occasional resync bytes, overflow and bad parity
        for (int p = 0; p < 24; p++) begin
            if ($urandom_range(7) == 0) begin
                junk = 8'($urandom);
                junk[3] = 1'b0;
                send_byte(junk, 1'b0, "rnd.junk");
            end
            rb0 = 8'($urandom);
            rb0[3] = 1'b1;
            if ($urandom_range(3) != 0) rb0[7:6] = 2'b00;
            rb1 = 8'($urandom);
            rb2 = 8'($urandom);
            bad_sel = int'($urandom_range(11));
            send_byte(rb0, bad_sel == 0, "rnd.b0");
            send_byte(rb1, bad_sel == 1, "rnd.b1");
            send_byte(rb2, bad_sel == 2, "rnd.b2");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
